// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed CPU priority instead of round-robin.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arbState_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic int lockCntWidth(input int maxLock);
    return $clog2(maxLock + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way winner select for the memory arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN makes the CPU win every unforced tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic i_rrLast,
`endif
  input  logic i_force,
  input  logic i_forcePort,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic w_winner;
  logic w_any;

  // A forced port (lock hold or starvation override) is only asserted while it requests.
  always_comb begin
    w_winner = PORT_CPU;
    w_any    = i_force || i_req0 || i_req1;
    if (i_force) begin
      w_winner = i_forcePort;
    end else if (i_req0 && i_req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      w_winner = PORT_CPU;
`else
      w_winner = ~i_rrLast;
`endif
    end else if (i_req1) begin
      w_winner = PORT_DMA;
    end
    o_gnt0 = w_any && (w_winner == PORT_CPU);
    o_gnt1 = w_any && (w_winner == PORT_DMA);
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port synchronous RAM between a CPU port (P0) and a DMA port (P1).
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority; default is round-robin.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int MAX_LOCK     = 8
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    P0_REQ,
  input  logic                    P0_WR,
  input  logic                    P0_LOCK,
  input  logic [ADDRESS_BITS-1:0] P0_ADDR,
  input  logic [BITS-1:0]         P0_DIN,
  output logic                    P0_GNT,
  output logic                    P0_RVALID,
  output logic [BITS-1:0]         P0_DOUT,
  input  logic                    P1_REQ,
  input  logic                    P1_WR,
  input  logic                    P1_LOCK,
  input  logic [ADDRESS_BITS-1:0] P1_ADDR,
  input  logic [BITS-1:0]         P1_DIN,
  output logic                    P1_GNT,
  output logic                    P1_RVALID,
  output logic [BITS-1:0]         P1_DOUT,
  output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
  output logic [BITS-1:0]         MEM_DATA_IN,
  input  logic [BITS-1:0]         MEM_DATA_OUT,
  output logic                    MEM_WRb
);

  localparam int            CW       = lockCntWidth(MAX_LOCK);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  arbState_t     r_state, w_nextState;
  logic [CW-1:0] r_lockCnt, w_nextLockCnt;
  logic          r_locked, w_nextLocked;
  logic          r_rvalid0, r_rvalid1;
  logic          w_owner, w_ownerReq, w_otherReq, w_lockHold, w_override;
  logic          w_pick0, w_pick1, w_gnt0, w_gnt1;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic          r_rrLast;
`endif

  // Lock hold keeps the previous owner; the override hands the RAM to a starved waiter.
  always_comb begin
    w_owner    = (r_state == ARB_OWN1) ? PORT_DMA : PORT_CPU;
    w_ownerReq = w_owner ? P1_REQ : P0_REQ;
    w_otherReq = w_owner ? P0_REQ : P1_REQ;
    w_lockHold = (r_state != ARB_IDLE) && r_locked && w_ownerReq;
    w_override = w_lockHold && w_otherReq && (r_lockCnt == LOCK_MAX);
  end

  mem_arb_pick u_pick (
    .i_req0      (P0_REQ),
    .i_req1      (P1_REQ),
`ifndef MEM_ARB_FIXED_PRIO_EN
    .i_rrLast    (r_rrLast),
`endif
    .i_force     (w_lockHold),
    .i_forcePort (w_override ? ~w_owner : w_owner),
    .o_gnt0      (w_pick0),
    .o_gnt1      (w_pick1)
  );

  assign w_gnt0 = w_pick0 && RSTb;
  assign w_gnt1 = w_pick1 && RSTb;

  always_comb begin
    w_nextState   = ARB_IDLE;
    w_nextLocked  = 1'b0;
    w_nextLockCnt = '0;
    if (w_gnt0) begin
      w_nextState  = ARB_OWN0;
      w_nextLocked = P0_LOCK;
    end else if (w_gnt1) begin
      w_nextState  = ARB_OWN1;
      w_nextLocked = P1_LOCK;
    end
    // Only a continued locked burst keeps its count; it advances while the other port waits.
    if (w_lockHold && !w_override && w_nextLocked) begin
      if (w_otherReq && (r_lockCnt != LOCK_MAX))
        w_nextLockCnt = r_lockCnt + CW'(1);
      else
        w_nextLockCnt = r_lockCnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_state   <= ARB_IDLE;
      r_lockCnt <= '0;
      r_locked  <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_lockCnt <= w_nextLockCnt;
      r_locked  <= w_nextLocked;
      r_rvalid0 <= w_gnt0 && !P0_WR;
      r_rvalid1 <= w_gnt1 && !P1_WR;
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  always_ff @(posedge CLK) begin
    if (!RSTb)
      r_rrLast <= PORT_DMA;
    else if (w_gnt0)
      r_rrLast <= PORT_CPU;
    else if (w_gnt1)
      r_rrLast <= PORT_DMA;
  end
`endif

  always_comb begin
    MEM_ADDRESS = '0;
    MEM_DATA_IN = '0;
    MEM_WRb     = 1'b1;
    if (w_gnt0) begin
      MEM_ADDRESS = P0_ADDR;
      MEM_DATA_IN = P0_DIN;
      MEM_WRb     = ~P0_WR;
    end else if (w_gnt1) begin
      MEM_ADDRESS = P1_ADDR;
      MEM_DATA_IN = P1_DIN;
      MEM_WRb     = ~P1_WR;
    end
  end

  // Reset masks a read strobe already in flight.
  assign P0_GNT    = w_gnt0;
  assign P1_GNT    = w_gnt1;
  assign P0_RVALID = r_rvalid0 && RSTb;
  assign P1_RVALID = r_rvalid1 && RSTb;
  assign P0_DOUT   = MEM_DATA_OUT;
  assign P1_DOUT   = MEM_DATA_OUT;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural single-port RAM (ADDRESS_BITS=8).
// Expectations follow MEM_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        P0_REQ, P0_WR, P0_LOCK, P1_REQ, P1_WR, P1_LOCK;
  logic [7:0]  P0_ADDR, P1_ADDR, MEM_ADDRESS;
  logic [15:0] P0_DIN, P1_DIN, P0_DOUT, P1_DOUT, MEM_DATA_IN, MEM_DATA_OUT;
  logic        P0_GNT, P1_GNT, P0_RVALID, P1_RVALID, MEM_WRb;

  logic [15:0] ram [0:255];
  int          checks = 0;
  int          errors = 0;
  logic        expG0, expG1, prevG1, p0Done;
  int          p1Count;

  memory_arbiter #(.BITS(16), .ADDRESS_BITS(8), .MAX_LOCK(8)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .P0_REQ(P0_REQ), .P0_WR(P0_WR), .P0_LOCK(P0_LOCK), .P0_ADDR(P0_ADDR), .P0_DIN(P0_DIN),
    .P0_GNT(P0_GNT), .P0_RVALID(P0_RVALID), .P0_DOUT(P0_DOUT),
    .P1_REQ(P1_REQ), .P1_WR(P1_WR), .P1_LOCK(P1_LOCK), .P1_ADDR(P1_ADDR), .P1_DIN(P1_DIN),
    .P1_GNT(P1_GNT), .P1_RVALID(P1_RVALID), .P1_DOUT(P1_DOUT),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATA_IN(MEM_DATA_IN), .MEM_DATA_OUT(MEM_DATA_OUT),
    .MEM_WRb(MEM_WRb)
  );

  always #5 CLK = ~CLK;

  // Synchronous single-port RAM: read data appears the cycle after the address.
  always @(posedge CLK) begin
    if (!MEM_WRb) ram[MEM_ADDRESS] <= MEM_DATA_IN;
    MEM_DATA_OUT <= ram[MEM_ADDRESS];
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic req0, input logic wr0, input logic lock0,
                               input logic [7:0] addr0, input logic [15:0] din0,
                               input logic req1, input logic wr1, input logic lock1,
                               input logic [7:0] addr1, input logic [15:0] din1);
    P0_REQ = req0; P0_WR = wr0; P0_LOCK = lock0; P0_ADDR = addr0; P0_DIN = din0;
    P1_REQ = req1; P1_WR = wr1; P1_LOCK = lock1; P1_ADDR = addr1; P1_DIN = din1;
  endtask

  task automatic applyIdle;
    applyStimulus(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    RSTb = 1'b0;
    applyIdle();
    tick();

    // Requests during reset must not reach the RAM.
    applyStimulus(1, 1, 0, 8'h12, 16'h5555, 1, 0, 0, 8'h20, 16'h0);
    #2;
    checkOutput("rst_gnt0", P0_GNT, 0);
    checkOutput("rst_gnt1", P1_GNT, 0);
    checkOutput("rst_wrb", MEM_WRb, 1);
    checkOutput("rst_rvalid0", P0_RVALID, 0);
    tick();
    RSTb = 1'b1;
    applyIdle();

    // Test 1: write then read back on P0.
    applyStimulus(1, 1, 0, 8'h12, 16'hBEEF, 0, 0, 0, 8'h00, 16'h0);
    #2;
    checkOutput("t1_wr_gnt0", P0_GNT, 1);
    checkOutput("t1_wr_gnt1", P1_GNT, 0);
    checkOutput("t1_wr_wrb", MEM_WRb, 0);
    checkOutput("t1_wr_addr", MEM_ADDRESS, 8'h12);
    checkOutput("t1_wr_data", MEM_DATA_IN, 16'hBEEF);
    tick();
    applyStimulus(1, 0, 0, 8'h12, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    #2;
    checkOutput("t1_rd_gnt0", P0_GNT, 1);
    checkOutput("t1_rd_wrb", MEM_WRb, 1);
    checkOutput("t1_no_rvalid_after_wr", P0_RVALID, 0);
    tick();
    applyIdle();
    #2;
    checkOutput("t1_rvalid0", P0_RVALID, 1);
    checkOutput("t1_dout0", P0_DOUT, 16'hBEEF);
    checkOutput("t1_rvalid1", P1_RVALID, 0);
    checkOutput("t1_idle_gnt0", P0_GNT, 0);
    tick();
    #2;
    checkOutput("t1_rvalid0_drop", P0_RVALID, 0);

    // Reset pulse so the first tie goes to P0.
    RSTb = 1'b0;
    tick();
    RSTb = 1'b1;

    // Test 2: continuous reads from both ports, no lock.
    applyStimulus(1, 0, 0, 8'h12, 16'h0, 1, 0, 0, 8'h20, 16'h0);
    prevG1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2;
`ifdef MEM_ARB_FIXED_PRIO_EN
      expG0 = 1'b1;
`else
      expG0 = (i % 2 == 0);
`endif
      expG1 = ~expG0;
      checkOutput($sformatf("t2_gnt0_c%0d", i), P0_GNT, expG0);
      checkOutput($sformatf("t2_gnt1_c%0d", i), P1_GNT, expG1);
      checkOutput($sformatf("t2_rvalid1_c%0d", i), P1_RVALID, prevG1);
      prevG1 = expG1;
      tick();
    end
    applyIdle();
    #2;
    checkOutput("t2_rvalid1_last", P1_RVALID, prevG1);
    tick();

    // Test 3: P1 locked burst of 20 reads, P0 arrives at cycle 3.
    p1Count = 0;
    p0Done  = 1'b0;
    for (int c = 0; c < 23; c++) begin
      applyStimulus((c >= 3) && !p0Done, 0, 0, 8'h12, 16'h0,
                    p1Count < 20, 0, 1, 8'h30, 16'h0);
      #2;
      expG0 = (c == 11);
      expG1 = (c <= 20) && (c != 11);
      checkOutput($sformatf("t3_gnt0_c%0d", c), P0_GNT, expG0);
      checkOutput($sformatf("t3_gnt1_c%0d", c), P1_GNT, expG1);
      if (P0_GNT) p0Done = 1'b1;
      if (P1_GNT) p1Count++;
      tick();
    end
    applyIdle();

    // Test 4: same-cycle P0 write and P1 read of one address.
    applyStimulus(1, 1, 0, 8'h40, 16'hAAAA, 0, 0, 0, 8'h00, 16'h0);
    #2;
    checkOutput("t4_prewrite_gnt0", P0_GNT, 1);
    tick();
    applyIdle();
    tick();
    applyStimulus(1, 1, 0, 8'h40, 16'h1234, 1, 0, 0, 8'h40, 16'h0);
    #2;
`ifdef MEM_ARB_FIXED_PRIO_EN
    checkOutput("t4_tie_gnt0", P0_GNT, 1);
    checkOutput("t4_tie_gnt1", P1_GNT, 0);
    checkOutput("t4_tie_wrb", MEM_WRb, 0);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h40, 16'h0);
    #2;
    checkOutput("t4_loser_gnt1", P1_GNT, 1);
    tick();
    applyIdle();
    #2;
    checkOutput("t4_rvalid1", P1_RVALID, 1);
    checkOutput("t4_dout1_new", P1_DOUT, 16'h1234);
`else
    checkOutput("t4_tie_gnt0", P0_GNT, 0);
    checkOutput("t4_tie_gnt1", P1_GNT, 1);
    checkOutput("t4_tie_wrb", MEM_WRb, 1);
    tick();
    applyStimulus(1, 1, 0, 8'h40, 16'h1234, 0, 0, 0, 8'h00, 16'h0);
    #2;
    checkOutput("t4_loser_gnt0", P0_GNT, 1);
    checkOutput("t4_loser_wrb", MEM_WRb, 0);
    checkOutput("t4_rvalid1", P1_RVALID, 1);
    checkOutput("t4_dout1_old", P1_DOUT, 16'hAAAA);
`endif
    tick();
    applyIdle();
    tick();

    // Test 5: reset asserted the cycle after a P0 read grant.
    applyStimulus(1, 0, 0, 8'h12, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    #2;
    checkOutput("t5_rd_gnt0", P0_GNT, 1);
    tick();
    RSTb = 1'b0;
    applyStimulus(1, 1, 0, 8'h12, 16'hDEAD, 0, 0, 0, 8'h00, 16'h0);
    for (int i = 0; i < 2; i++) begin
      #2;
      checkOutput($sformatf("t5_rvalid0_r%0d", i), P0_RVALID, 0);
      checkOutput($sformatf("t5_gnt0_r%0d", i), P0_GNT, 0);
      checkOutput($sformatf("t5_wrb_r%0d", i), MEM_WRb, 1);
      tick();
    end
    RSTb = 1'b1;
    applyStimulus(1, 0, 0, 8'h12, 16'h0, 1, 0, 0, 8'h20, 16'h0);
    #2;
    checkOutput("t5_tie_gnt0", P0_GNT, 1);
    checkOutput("t5_tie_gnt1", P1_GNT, 0);
    tick();
    applyIdle();
    #2;
    checkOutput("t5_rvalid0", P0_RVALID, 1);
    checkOutput("t5_ram_intact", P0_DOUT, 16'hBEEF);
    tick();

    // Test 6: ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      #2;
      checkOutput($sformatf("t6_idle_c%0d", i),
                  {MEM_WRb, P0_GNT, P1_GNT, P0_RVALID, P1_RVALID}, 5'b10000);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
